// File: rtl/bp_cce_hybrid_mode_ctrl_pkg.sv
// rtl/bp_cce_hybrid_mode_ctrl_pkg.sv - shared CCE mode type used by the mode controller and its clients
package bp_cce_hybrid_mode_ctrl_pkg;

  typedef enum logic [0:0] {
    e_cce_mode_normal   = 1'b0,
    e_cce_mode_uncached = 1'b1
  } bp_cce_mode_e;

endpackage

// File: rtl/bp_cce_hybrid_mode_ctrl_if.sv
// rtl/bp_cce_hybrid_mode_ctrl_if.sv - ready&valid mode-change request channel
interface bp_cce_hybrid_mode_ctrl_if
  import bp_cce_hybrid_mode_ctrl_pkg::*;
();

  logic         mode_w_v_i;
  logic         mode_w_ready_and_o;
  bp_cce_mode_e mode_w_i;

  modport master (output mode_w_v_i, output mode_w_i, input mode_w_ready_and_o);
  modport slave  (input mode_w_v_i, input mode_w_i, output mode_w_ready_and_o);

endinterface

// File: rtl/bsg_counter_clear_up.sv
// rtl/bsg_counter_clear_up.sv - up counter with synchronous clear; clear and up together load 1
module bsg_counter_clear_up #(
  parameter int max_val_p  = 1,
  parameter int init_val_p = 0,
  localparam int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o <= width_lp'(init_val_p);
    end else if (clear_i) begin
      count_o <= width_lp'(up_i);
    end else if (up_i) begin
      count_o <= count_o + width_lp'(1);
    end
  end

endmodule

// File: rtl/bp_cce_hybrid_mode_ctrl.sv
// rtl/bp_cce_hybrid_mode_ctrl.sv - drains CCE pipes before switching mode; watchdog under BP_CCE_MODE_CTRL_DRAIN_TIMEOUT_EN
module bp_cce_hybrid_mode_ctrl
  import bp_cce_hybrid_mode_ctrl_pkg::*;
#(
  parameter int           num_pipes_p     = 3,
  parameter int           settle_cycles_p = 2,
  parameter bp_cce_mode_e reset_mode_p    = e_cce_mode_uncached,
  parameter int           drain_timeout_p = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bp_cce_hybrid_mode_ctrl_if.slave mode_if,
  input  logic [num_pipes_p-1:0]   pipe_empty_i,
  output logic                     stall_o,
  output bp_cce_mode_e             cce_mode_o,
  output logic                     switch_done_o,
  output logic                     drain_timeout_o
);

  typedef enum logic [1:0] {
    e_ready,
    e_drain,
    e_settle,
    e_switch
  } state_e;

  localparam int settle_w_lp = $clog2(settle_cycles_p + 1);
  localparam logic [settle_w_lp-1:0] settle_last_lp = settle_w_lp'(settle_cycles_p - 1);

  state_e                 state_r, state_n;
  bp_cce_mode_e           pending_r;
  logic                   same_done_r;
  logic [settle_w_lp-1:0] settle_cnt;
  logic                   all_empty, hs, same_mode;

  assign all_empty = &pipe_empty_i;
  assign mode_if.mode_w_ready_and_o = (state_r == e_ready);
  assign hs        = mode_if.mode_w_v_i & mode_if.mode_w_ready_and_o;
  assign same_mode = (mode_if.mode_w_i == cce_mode_o);

  // Counter is only meaningful in e_settle; everywhere else it is held at zero.
  bsg_counter_clear_up #(
    .max_val_p (settle_cycles_p),
    .init_val_p(0)
  ) settle_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (state_r != e_settle),
    .up_i     ((state_r == e_settle) & all_empty),
    .count_o  (settle_cnt)
  );

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_ready:  if (hs && !same_mode) state_n = e_drain;
      e_drain:  if (all_empty) state_n = e_settle;
      e_settle: begin
        if (!all_empty) state_n = e_drain;
        else if (settle_cnt == settle_last_lp) state_n = e_switch;
      end
      e_switch: state_n = e_ready;
      default:  state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_ready;
      cce_mode_o  <= reset_mode_p;
      pending_r   <= e_cce_mode_normal;
      same_done_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      same_done_r <= hs & same_mode;
      if (hs && !same_mode) pending_r <= mode_if.mode_w_i;
      // Mode moves one cycle ahead of the stall release so pipes restart in the new mode.
      if (state_r == e_settle && state_n == e_switch) cce_mode_o <= pending_r;
    end
  end

  assign stall_o       = (state_r != e_ready);
  assign switch_done_o = (state_r == e_switch) | same_done_r;

`ifdef BP_CCE_MODE_CTRL_DRAIN_TIMEOUT_EN
  localparam int wd_w_lp = $clog2(drain_timeout_p + 1);

  logic [wd_w_lp-1:0] wd_cnt;
  logic               waiting, wd_flag_r;

  assign waiting = (state_r == e_drain) | (state_r == e_settle);

  bsg_counter_clear_up #(
    .max_val_p (drain_timeout_p),
    .init_val_p(0)
  ) wd_counter (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (state_r == e_ready),
    .up_i     (waiting & (wd_cnt != wd_w_lp'(drain_timeout_p))),
    .count_o  (wd_cnt)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_flag_r <= 1'b0;
    end else if (waiting && wd_cnt == wd_w_lp'(drain_timeout_p - 1)) begin
      wd_flag_r <= 1'b1;
    end
  end

  assign drain_timeout_o = wd_flag_r;
`else
  // Watchdog compiled out: the flag is constant zero.
  assign drain_timeout_o = 1'b0 & (drain_timeout_p > 0);
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_mode_ctrl.sv
// tb/tb_bp_cce_hybrid_mode_ctrl.sv - randomized and directed checks of the CCE mode controller
module tb_bp_cce_hybrid_mode_ctrl;
  import bp_cce_hybrid_mode_ctrl_pkg::*;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 8;
`ifdef BP_CCE_MODE_CTRL_DRAIN_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   pipe_empty;
  logic         stall, switch_done, drain_timeout;
  bp_cce_mode_e cce_mode;

  bp_cce_hybrid_mode_ctrl_if mif ();

  bp_cce_hybrid_mode_ctrl #(
    .num_pipes_p    (3),
    .settle_cycles_p(SETTLE),
    .reset_mode_p   (e_cce_mode_uncached),
    .drain_timeout_p(TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .mode_if        (mif),
    .pipe_empty_i   (pipe_empty),
    .stall_o        (stall),
    .cce_mode_o     (cce_mode),
    .switch_done_o  (switch_done),
    .drain_timeout_o(drain_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: a request is outstanding until the pipes have been seen
  // empty for SETTLE+1 consecutive stalled cycles; then one done/switch cycle.
  bit           m_busy, m_sw, m_same, m_flag;
  int           m_run, m_wcnt;
  bp_cce_mode_e m_mode, m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sw = 0; m_same = 0; m_flag = 0;
    m_run = 0; m_wcnt = 0;
    m_mode = e_cce_mode_uncached; m_pend = e_cce_mode_normal;
  endtask

  task automatic model_step(input logic v, input bp_cce_mode_e w, input logic [2:0] e);
    bit sw_n, same_n;
    sw_n = 0; same_n = 0;
    if (m_busy) begin
      if (WD_EN) begin
        m_wcnt++;
        if (m_wcnt >= TIMEOUT) m_flag = 1;
      end
      m_run = (e == 3'b111) ? m_run + 1 : 0;
      if (m_run == SETTLE + 1) begin
        m_busy = 0; sw_n = 1; m_mode = m_pend;
      end
    end else if (!m_sw && v) begin
      if (w == m_mode) same_n = 1;
      else begin
        m_busy = 1; m_pend = w; m_run = 0; m_wcnt = 0;
      end
    end
    m_sw = sw_n; m_same = same_n;
  endtask

  // One cycle: check this cycle's outputs, then drive this cycle's inputs.
  task automatic cyc(input logic v, input bp_cce_mode_e w, input logic [2:0] e);
    @(negedge clk);
    cycle++;
    check_eq("stall", stall, m_busy || m_sw);
    check_eq("ready", mif.mode_w_ready_and_o, !(m_busy || m_sw));
    check_eq("mode", cce_mode, m_mode);
    check_eq("done", switch_done, m_sw || m_same);
    check_eq("timeout", drain_timeout, m_flag);
    mif.mode_w_v_i = v;
    mif.mode_w_i   = w;
    pipe_empty     = e;
    model_step(v, w, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, e_cce_mode_normal, 3'b111);
  endtask

  bp_cce_mode_e other;
  int h, first_mode, first_free, first_empty;

  initial begin
    reset_n = 1'b0;
    mif.mode_w_v_i = 1'b0;
    mif.mode_w_i   = e_cce_mode_normal;
    pipe_empty     = 3'b111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", stall, 0);
    check_eq("rst_mode", cce_mode, e_cce_mode_uncached);
    check_eq("rst_done", switch_done, 0);
    check_eq("rst_ready", mif.mode_w_ready_and_o, 1);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    // Same-mode write: pulse only, no stall.
    cyc(1'b1, e_cce_mode_uncached, 3'b111);
    idle(3);

    // Switch to normal with empty pipes; measure latency independently.
    cyc(1'b1, e_cce_mode_normal, 3'b111);
    h = cycle; first_mode = -1; first_free = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, e_cce_mode_normal, 3'b111);
      if (first_mode < 0 && cce_mode == e_cce_mode_normal) first_mode = cycle;
      if (first_free < 0 && !stall) first_free = cycle;
    end
    check_eq("lat_mode", first_mode - h, SETTLE + 2);
    check_eq("lat_stall", first_free - h, SETTLE + 3);

    // Pipe 1 busy for 20 cycles, then empty.
    cyc(1'b1, e_cce_mode_uncached, 3'b111);
    for (int i = 0; i < 20; i++) cyc(1'b0, e_cce_mode_normal, 3'b101);
    first_empty = cycle + 1; first_mode = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, e_cce_mode_normal, 3'b111);
      if (first_mode < 0 && cce_mode == e_cce_mode_uncached) first_mode = cycle;
    end
    check_eq("drain_lat", first_mode - first_empty, SETTLE + 1);

    // Single empty cycle then busy again: must go back to draining.
    cyc(1'b1, e_cce_mode_normal, 3'b111);
    cyc(1'b0, e_cce_mode_normal, 3'b000);
    cyc(1'b0, e_cce_mode_normal, 3'b111);
    cyc(1'b0, e_cce_mode_normal, 3'b011);
    cyc(1'b0, e_cce_mode_normal, 3'b111);
    cyc(1'b0, e_cce_mode_normal, 3'b110);
    idle(8);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) == 0), bp_cce_mode_e'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 7)));
    end
    idle(6);

    // Reset while settling abandons the request.
    other = (m_mode == e_cce_mode_normal) ? e_cce_mode_uncached : e_cce_mode_normal;
    if (m_mode == e_cce_mode_uncached) begin
      cyc(1'b1, other, 3'b111);
      idle(4);
      other = e_cce_mode_uncached;
    end
    cyc(1'b1, other, 3'b111);
    cyc(1'b0, e_cce_mode_normal, 3'b111);
    cyc(1'b0, e_cce_mode_normal, 3'b111);
    check_eq("pre_rst_stall", stall, 1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_stall", stall, 0);
    check_eq("mid_rst_mode", cce_mode, e_cce_mode_uncached);
    check_eq("mid_rst_done", switch_done, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
